// File: rtl/relation_seq_gen_if.sv
// Handshake and control bundle for relation_seq_gen: the master side commands
// sequences and accepts pairs, the slave side (the generator) produces them.
interface relation_seq_gen_if #(
    parameter int WIDTH = 3
);
    logic             start_i;
    logic [WIDTH-1:0] seed_i;
    logic [1:0]       mode_i;
    logic [3:0]       len_i;
    logic             ready_i;
    logic             valid_o;
    logic [WIDTH-1:0] a_out_o;
    logic [WIDTH-1:0] b_out_o;
    logic             busy_o;
    logic             done_o;
    logic             trunc_o;

    modport master (
        output start_i, seed_i, mode_i, len_i, ready_i,
        input  valid_o, a_out_o, b_out_o, busy_o, done_o, trunc_o
    );

    modport slave (
        input  start_i, seed_i, mode_i, len_i, ready_i,
        output valid_o, a_out_o, b_out_o, busy_o, done_o, trunc_o
    );
endinterface

// File: rtl/relation_seq_gen.sv
// Emits (a, b) pairs obeying a Gray/+1/-1/+3 relation over valid/ready.
// Define RELSEQ_WRAP_EN to wrap arithmetic modes instead of truncating at range edges.
module relation_seq_gen #(
    parameter int WIDTH = 3
) (
    input logic              clk,
    input logic              rst_n,
    relation_seq_gen_if.slave bus
);

`ifdef RELSEQ_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, seed_q, seed_d, k_q, k_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       len_q, len_d, cnt_q, cnt_d;
    logic             valid_q, valid_d, busy_q, busy_d;
    logic             done_q, done_d, trunc_q, trunc_d;
    logic [WIDTH:0]   startStep, runStep;
    logic [WIDTH-1:0] kPlus2;
    logic             startCross, runCross, lastPair;

    // The extra top bit carries the carry/borrow that flags a range crossing.
    function automatic logic [WIDTH:0] arithStep(input logic [WIDTH-1:0] v,
                                                 input logic [1:0] m);
        logic [WIDTH:0] x;
        x = {1'b0, v};
        case (m)
            2'b01:   arithStep = x + (WIDTH+1)'(1);
            2'b10:   arithStep = x - (WIDTH+1)'(1);
            2'b11:   arithStep = x + (WIDTH+1)'(3);
            default: arithStep = {1'b0, v ^ WIDTH'(1)};
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] grayCode(input logic [WIDTH-1:0] k);
        grayCode = k ^ (k >> 1);
    endfunction

    always_comb begin
        kPlus2     = k_q + WIDTH'(2);
        startStep  = arithStep(bus.seed_i, bus.mode_i);
        runStep    = (mode_q == 2'b00) ? {1'b0, seed_q ^ grayCode(kPlus2)}
                                       : arithStep(b_q, mode_q);
        startCross = !WrapEn && startStep[WIDTH];
        runCross   = !WrapEn && runStep[WIDTH];
        lastPair   = (cnt_q + 4'd1) == len_q;

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        seed_d  = seed_q;
        k_d     = k_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        trunc_d = trunc_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    seed_d  = bus.seed_i;
                    mode_d  = bus.mode_i;
                    len_d   = bus.len_i;
                    k_d     = '0;
                    cnt_d   = '0;
                    trunc_d = 1'b0;
                    if (bus.len_i == 4'd0) begin
                        done_d = 1'b1;
                    end else if (startCross) begin
                        done_d  = 1'b1;
                        trunc_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        a_d     = bus.seed_i;
                        b_d     = startStep[WIDTH-1:0];
                    end
                end
            end
            RUN: begin
                // A crossing only truncates when more pairs were still owed.
                if (bus.ready_i) begin
                    if (lastPair || runCross) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        trunc_d = runCross && !lastPair;
                    end else begin
                        a_d   = b_q;
                        b_d   = runStep[WIDTH-1:0];
                        k_d   = k_q + WIDTH'(1);
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            seed_q  <= '0;
            k_q     <= '0;
            mode_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            seed_q  <= seed_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            trunc_q <= trunc_d;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.a_out_o = a_q;
    assign bus.b_out_o = b_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.trunc_o = trunc_q;

endmodule

// File: tb/tb_relation_seq_gen.sv
// Directed, table-driven bench for relation_seq_gen; expected values are hand-computed.
module tb_relation_seq_gen;
    localparam int WIDTH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    relation_seq_gen_if #(.WIDTH(WIDTH)) bus();

    relation_seq_gen #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic       st;
        logic [2:0] sd;
        logic [1:0] md;
        logic [3:0] ln;
        logic       rdy;
        logic       v;
        logic [2:0] a;
        logic [2:0] b;
        logic       by;
        logic       dn;
        logic       tr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   lastA, lastB;

    // One row: inputs driven before an edge, outputs expected after that edge.
    task automatic addVec(input string n, input int st, input int sd, input int md,
                          input int ln, input int rdy, input int v, input int a,
                          input int b, input int by, input int dn, input int tr);
        vec_t x;
        x.name = n;
        x.st   = 1'(st);
        x.sd   = 3'(sd);
        x.md   = 2'(md);
        x.ln   = 4'(ln);
        x.rdy  = 1'(rdy);
        x.v    = 1'(v);
        x.a    = 3'(a);
        x.b    = 3'(b);
        x.by   = 1'(by);
        x.dn   = 1'(dn);
        x.tr   = 1'(tr);
        vecs.push_back(x);
    endtask

    task automatic applyStimulus(input int st, input int sd, input int md,
                                 input int ln, input int rdy);
        bus.start_i = 1'(st);
        bus.seed_i  = 3'(sd);
        bus.mode_i  = 2'(md);
        bus.len_i   = 4'(ln);
        bus.ready_i = 1'(rdy);
    endtask

    task automatic checkOutput(input string n, input int v, input int a, input int b,
                               input int by, input int dn, input int tr);
        logic [9:0] act, exp;
        act = {bus.valid_o, bus.a_out_o, bus.b_out_o, bus.busy_o, bus.done_o, bus.trunc_o};
        exp = {1'(v), 3'(a), 3'(b), 1'(by), 1'(dn), 1'(tr)};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b a=%0d b=%0d busy=%b done=%b trunc=%b, want valid=%b a=%0d b=%0d busy=%b done=%b trunc=%b",
                     n, act[9], act[8:6], act[5:3], act[2], act[1], act[0],
                     exp[9], exp[8:6], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int grayOf(input int k);
        int m;
        m = k % 8;
        return m ^ (m >> 1);
    endfunction

    initial begin
        applyStimulus(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        addVec("inc0",     1, 2, 1, 4, 1, 1, 2, 3, 1, 0, 0);
        addVec("inc1",     0, 2, 1, 4, 1, 1, 3, 4, 1, 0, 0);
        addVec("inc2",     0, 2, 1, 4, 1, 1, 4, 5, 1, 0, 0);
        addVec("inc3",     0, 2, 1, 4, 1, 1, 5, 6, 1, 0, 0);
        addVec("incDone",  0, 2, 1, 4, 1, 0, 5, 6, 0, 1, 0);
        addVec("gray0",    1, 5, 0, 3, 1, 1, 5, 4, 1, 0, 0);
        addVec("gray1",    0, 5, 0, 3, 1, 1, 4, 6, 1, 0, 0);
        addVec("gray2",    0, 5, 0, 3, 1, 1, 6, 7, 1, 0, 0);
        addVec("grayDone", 0, 5, 0, 3, 1, 0, 6, 7, 0, 1, 0);
        addVec("grayIdle", 0, 5, 0, 3, 1, 0, 6, 7, 0, 0, 0);
`ifdef RELSEQ_WRAP_EN
        addVec("ex3_0",    1, 6, 3, 2, 1, 1, 6, 1, 1, 0, 0);
        addVec("ex3_1",    0, 6, 3, 2, 1, 1, 1, 4, 1, 0, 0);
        addVec("ex3Done",  0, 6, 3, 2, 1, 0, 1, 4, 0, 1, 0);
        addVec("dec0",     1, 1, 2, 3, 1, 1, 1, 0, 1, 0, 0);
        addVec("dec1",     0, 1, 2, 3, 1, 1, 0, 7, 1, 0, 0);
        addVec("dec2",     0, 1, 2, 3, 1, 1, 7, 6, 1, 0, 0);
        addVec("decDone",  0, 1, 2, 3, 1, 0, 7, 6, 0, 1, 0);
        lastA = 7;
        lastB = 6;
`else
        addVec("ex3Trunc", 1, 6, 3, 2, 1, 0, 6, 7, 0, 1, 1);
        addVec("ex3Hold",  0, 6, 3, 2, 1, 0, 6, 7, 0, 0, 1);
        addVec("dec0",     1, 1, 2, 3, 1, 1, 1, 0, 1, 0, 0);
        addVec("decTrunc", 0, 1, 2, 3, 1, 0, 1, 0, 0, 1, 1);
        lastA = 1;
        lastB = 0;
`endif
        addVec("len0",     1, 3, 1, 0, 1, 0, lastA, lastB, 0, 1, 0);
        addVec("len0Idle", 0, 3, 1, 0, 1, 0, lastA, lastB, 0, 0, 0);
        addVec("incEdge",  1, 6, 1, 1, 1, 1, 6, 7, 1, 0, 0);
        addVec("incEdgeDn",0, 6, 1, 1, 1, 0, 6, 7, 0, 1, 0);
        // Nine Gray pairs from seed 0 so the 3-bit counter wraps mid-sequence.
        for (int k = 0; k < 9; k++)
            addVec($sformatf("grayWrap%0d", k), (k == 0) ? 1 : 0, 0, 0, 9, 1,
                   1, grayOf(k), grayOf(k + 1), 1, 0, 0);
        addVec("grayWrapDn",0, 0, 0, 9, 1, 0, grayOf(8), grayOf(9), 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].st, vecs[i].sd, vecs[i].md, vecs[i].ln, vecs[i].rdy);
            stepCycle();
            checkOutput(vecs[i].name, vecs[i].v, vecs[i].a, vecs[i].b,
                        vecs[i].by, vecs[i].dn, vecs[i].tr);
        end

        // Backpressure with a stray start and changed mode/seed/len mid-run.
        applyStimulus(1, 0, 1, 2, 0);
        stepCycle();
        checkOutput("bpStart", 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus((i == 1) ? 1 : 0, 5, 2, 7, 0);
            stepCycle();
            checkOutput($sformatf("bpHold%0d", i), 1, 0, 1, 1, 0, 0);
        end
        applyStimulus(0, 5, 2, 7, 1);
        stepCycle();
        checkOutput("bpXfer", 1, 1, 2, 1, 0, 0);
        stepCycle();
        checkOutput("bpDone", 0, 1, 2, 0, 1, 0);

        // Asynchronous reset in the middle of a run.
        applyStimulus(1, 2, 1, 8, 1);
        stepCycle();
        checkOutput("rstRun0", 1, 2, 3, 1, 0, 0);
        applyStimulus(0, 2, 1, 8, 1);
        stepCycle();
        checkOutput("rstRun1", 1, 3, 4, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("rstAsync", 0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("rstHeld", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("rstIdle", 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 6, 1, 1, 1);
        stepCycle();
        checkOutput("postRst", 1, 6, 7, 1, 0, 0);
        applyStimulus(0, 6, 1, 1, 1);
        stepCycle();
        checkOutput("postRstDn", 0, 6, 7, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/relation_seq_gen.md
# relation_seq_gen

Sequential generator for 3-bit value pairs with a known relation. Given a seed, a relation mode and a length, it emits a stream of (a, b) pairs over a valid/ready handshake. Every emitted pair satisfies the commanded relation: Gray-adjacent, b = a+1, b = a−1 or b = a+3. It is the stimulus/producer counterpart of the pair-relation classifier. It drives classifier inputs and downstream consumers that expect related code sequences.

## Interface
- WIDTH, 3, width of a_out/b_out/seed
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sequence; sampled only in IDLE
- seed  input  WIDTH  first value of the sequence
- mode  input  2  00 gray step, 01 increment (+1), 10 decrement (−1), 11 excess-3 (+3)
- len  input  4  number of pairs to emit, 0..15
- ready  input  1  consumer accepts the current pair
- valid  output  1  a_out/b_out hold a pair
- a_out  output  WIDTH  first element of the pair
- b_out  output  WIDTH  second element of the pair
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse at end of sequence
- trunc  output  1  sequence ended early on a range boundary; held until the next accepted start

## Operation
- States:
  - IDLE: valid=0, busy=0.
  - RUN: valid=1, busy=1.
- IDLE → RUN on start=1. The block latches seed, mode and len. It clears the index k and trunc. It sets a_out=v0=seed and b_out=v1.
- The value sequence is v0=seed, v(k+1)=step(vk). Pair k is (vk, vk+1), for k = 0..len−1.
- Step rules:
  - gray: vk = seed ^ G(k), where G(k) = k ^ (k>>1) and k is a WIDTH-bit counter (wraps mod 2^WIDTH). Consecutive values always differ in exactly one bit, including across the counter wrap.
  - +1: v+1.
  - −1: v−1.
  - +3: v+3.
  - All arithmetic is WIDTH+1 bits wide; the carry/borrow bit detects a range crossing.
- Handshake:
  - A pair transfers on a cycle with valid=1 and ready=1.
  - While valid=1 and ready=0, a_out and b_out hold stable.
  - On transfer: a_out ← b_out, b_out ← step(b_out), k ← k+1.
- Termination (RUN → IDLE):
  - Normal end: the handshake on pair len−1 ends the sequence. done pulses, busy and valid drop, and a_out/b_out hold their last values.
- len=0: the block enters no RUN cycles and emits no pairs. done pulses the cycle after start.
- start while busy=1 is ignored. Mode, seed and len changes during RUN are ignored.
- Range crossing (arithmetic modes only; gray never crosses) follows RELSEQ_WRAP_EN, described under Configuration.
- Reset mid-sequence: all outputs clear asynchronously and the FSM returns to IDLE. No done pulse is issued.

## Timing
- Reset values: valid=0, a_out=0, b_out=0, busy=0, done=0, trunc=0, state IDLE.
- Latency: start sampled at edge N gives valid=1 with pair 0 after edge N.
- Throughput: one pair per cycle while ready=1.
- done is registered. It is high in the cycle after the final transfer, coincident with valid=0 and busy=0.
- The earliest new start is accepted in the done cycle, because the FSM is already in IDLE.

## Configuration
- RELSEQ_WRAP_EN defined:
  - +1/−1/+3 wrap modulo 2^WIDTH (for example 7+1=0, 0−1=7, 6+3=1).
  - trunc is never set.
- RELSEQ_WRAP_EN undefined:
  - A pair whose b would cross 0 or 2^WIDTH−1 is never presented.
  - If this happens at start (pair 0 invalid), valid never rises. done and trunc assert the cycle after start.
  - If this happens after a transfer (next pair invalid), the sequence ends as a normal end with trunc=1.

## Test plan
- mode=01, seed=2, len=4, ready=1:
  - Pairs are (2,3), (3,4), (4,5), (5,6) on 4 consecutive cycles.
  - done is high 1 cycle later.
  - trunc=0.
- mode=00, seed=5, len=3:
  - Pairs are (5,4), (4,6), (6,7).
  - Each pair differs in exactly one bit.
- mode=11, seed=6, len=2:
  - With RELSEQ_WRAP_EN: pairs (6,1), (1,4).
  - Without RELSEQ_WRAP_EN: no valid; done=1 and trunc=1 the cycle after start.
- mode=10, seed=1, len=3:
  - With RELSEQ_WRAP_EN: pairs (1,0), (0,7), (7,6).
  - Without RELSEQ_WRAP_EN: only (1,0), then done=1 and trunc=1.
- Backpressure:
  - mode=01, seed=0, len=2, ready low for 3 cycles: (0,1) holds stable, then transfers. start pulsed mid-run is ignored.
  - len=0: done the cycle after start, with no valid.
- Reset mid-sequence: rst_n low during RUN clears valid, busy, a_out and b_out immediately (before the next edge). No done pulse is issued. The FSM is in IDLE after release.
